// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect requests and imem data in, PC and instruction out.
// Optional PC_FETCH_PERF_EN adds the retired_cnt / redirect_cnt counters.
interface pc_fetch_unit_if #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
);
   logic             stall;
   logic             br_taken;
   logic [PC_W-1:0]  br_target;
   logic             jalr_taken;
   logic [PC_W-1:0]  jalr_target;
   logic [INS_W-1:0] imem_rd;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_plus4;
   logic [INS_W-1:0] instr;
   logic             instr_valid;
   logic             halted;
   logic             misaligned;
`ifdef PC_FETCH_PERF_EN
   logic [31:0]      retired_cnt;
   logic [31:0]      redirect_cnt;
`endif

   modport master (
`ifdef PC_FETCH_PERF_EN
      output retired_cnt,
      output redirect_cnt,
`endif
      input  stall,
      input  br_taken,
      input  br_target,
      input  jalr_taken,
      input  jalr_target,
      input  imem_rd,
      output pc,
      output pc_plus4,
      output instr,
      output instr_valid,
      output halted,
      output misaligned
   );

   modport slave (
`ifdef PC_FETCH_PERF_EN
      input  retired_cnt,
      input  redirect_cnt,
`endif
      output stall,
      output br_taken,
      output br_target,
      output jalr_taken,
      output jalr_target,
      output imem_rd,
      input  pc,
      input  pc_plus4,
      input  instr,
      input  instr_valid,
      input  halted,
      input  misaligned
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / fetch stage: BOOT -> RUN -> HALT, next-PC select, halt/misalign stop.
// Optional PC_FETCH_PERF_EN adds saturating retired/redirect counters.
module pc_fetch_unit #(
   parameter int               PC_W       = 9,
   parameter int               INS_W      = 32,
   parameter logic [PC_W-1:0]  RESET_PC   = '0,
   parameter logic [INS_W-1:0] HALT_INSTR = 32'h00000073
) (
   input logic            clk,
   input logic            reset,
   pc_fetch_unit_if.master bus
);
   localparam logic [INS_W-1:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic            mis_q;

   logic [PC_W-1:0] jalr_tgt;
   logic [PC_W-1:0] redir_tgt;
   logic            redir;
   logic            tgt_mis;
   logic            is_halt;
   logic            run_go;

   // Redirect target select (JALR over branch) and stop conditions
   always_comb begin
      jalr_tgt  = bus.jalr_target & ~PC_W'(1);
      redir     = bus.jalr_taken | bus.br_taken;
      redir_tgt = bus.jalr_taken ? jalr_tgt : bus.br_target;
      tgt_mis   = redir && (redir_tgt[1:0] != 2'b00);
      is_halt   = (bus.imem_rd == HALT_INSTR);
      run_go    = (state_q == ST_RUN) && !bus.stall;
   end

   // Fetch FSM and PC register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         mis_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_BOOT: state_q <= ST_RUN;
            ST_RUN: begin
               if (!bus.stall) begin
                  if (is_halt) begin
                     state_q <= ST_HALT;
                  end else if (tgt_mis) begin
                     state_q <= ST_HALT;
                     mis_q   <= 1'b1;
                  end else if (redir) begin
                     pc_q <= redir_tgt;
                  end else begin
                     pc_q <= pc_q + PC_W'(4);
                  end
               end
            end
            ST_HALT: state_q <= ST_HALT;
            default: state_q <= ST_HALT;
         endcase
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      bus.pc          = pc_q;
      bus.pc_plus4    = pc_q + PC_W'(4);
      bus.instr_valid = (state_q == ST_RUN);
      bus.instr       = (state_q == ST_RUN) ? bus.imem_rd : NOP;
      bus.halted      = (state_q == ST_HALT);
      bus.misaligned  = mis_q;
   end

`ifdef PC_FETCH_PERF_EN
   logic [31:0] ret_q;
   logic [31:0] red_q;

   // Saturating retired / accepted-redirect counters
   always_ff @(posedge clk) begin
      if (reset) begin
         ret_q <= '0;
         red_q <= '0;
      end else if (run_go && !is_halt) begin
         if (ret_q != '1) ret_q <= ret_q + 32'd1;
         if (redir && !tgt_mis && red_q != '1)
            red_q <= red_q + 32'd1;
      end
   end

   assign bus.retired_cnt  = ret_q;
   assign bus.redirect_cnt = red_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a spec model pushes expected
// per-cycle outputs, which are popped and compared after each edge.
module tb_pc_fetch_unit;
   localparam logic [31:0] HALT = 32'h00000073;
   localparam logic [31:0] NOP  = 32'h00000013;

   typedef struct {
      logic [8:0]  pc;
      logic [8:0]  pc4;
      logic        valid;
      logic        halted;
      logic        mis;
      logic [31:0] instr;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] mem [128];
   exp_t sb_q [$];

   int n_tot  = 0;
   int n_pass = 0;

   // model state: 0 BOOT, 1 RUN, 2 HALT
   int         m_st  = 0;
   logic [8:0] m_pc  = '0;
   logic       m_mis = 1'b0;

   pc_fetch_unit_if bus ();

   pc_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.imem_rd = mem[bus.pc[8:2]];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic step(bit rst, bit st, bit br, logic [8:0] bt,
                       bit jr, logic [8:0] jt);
      exp_t e;
      logic [8:0] t;
      reset          = rst;
      bus.stall      = st;
      bus.br_taken   = br;
      bus.br_target  = bt;
      bus.jalr_taken = jr;
      bus.jalr_target = jt;
      if (rst) begin
         m_st = 0; m_pc = '0; m_mis = 1'b0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1 && !st) begin
         if (mem[m_pc[8:2]] == HALT) begin
            m_st = 2;
         end else if (jr || br) begin
            t = jr ? {jt[8:1], 1'b0} : bt;
            if (t[1:0] != 2'b00) begin
               m_st = 2; m_mis = 1'b1;
            end else begin
               m_pc = t;
            end
         end else begin
            m_pc = m_pc + 9'd4;
         end
      end
      e.pc     = m_pc;
      e.pc4    = m_pc + 9'd4;
      e.valid  = (m_st == 1);
      e.halted = (m_st == 2);
      e.mis    = m_mis;
      e.instr  = (m_st == 1) ? mem[m_pc[8:2]] : NOP;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("pc",       32'(bus.pc),          32'(e.pc));
      chk("pc_plus4", 32'(bus.pc_plus4),    32'(e.pc4));
      chk("valid",    32'(bus.instr_valid), 32'(e.valid));
      chk("halted",   32'(bus.halted),      32'(e.halted));
      chk("misalign", 32'(bus.misaligned),  32'(e.mis));
      chk("instr",    bus.instr,            e.instr);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
   endtask

   initial begin
      logic [31:0] w;
      logic [8:0]  bt, jt;
      for (int i = 0; i < 128; i++) begin
         do w = $urandom; while (w == HALT);
         mem[i] = w;
      end
      mem[16] = HALT;
      reset = 1'b1;
      bus.stall = 0; bus.br_taken = 0; bus.jalr_taken = 0;
      bus.br_target = '0; bus.jalr_target = '0;

      step(1, 0, 0, '0, 0, '0);
      chk("rst_pc", 32'(bus.pc), 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_instr", bus.instr, NOP);
      run(1);
      chk("run_pc0", 32'(bus.pc), 32'h0);
      chk("run_val", 32'(bus.instr_valid), 32'h1);
      run(2);
      chk("run_pc8", 32'(bus.pc), 32'h8);

      step(0, 0, 1, 9'h030, 0, '0);
      chk("pc4_30", 32'(bus.pc_plus4), 32'h34);
      step(0, 0, 1, 9'h054, 0, '0);
      chk("br_54", 32'(bus.pc), 32'h54);
      step(0, 0, 1, 9'h010, 1, 9'h065);
      chk("jalr_64", 32'(bus.pc), 32'h64);

      step(0, 0, 1, 9'h01C, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 9'h100, 0, '0);
      chk("stall_1c", 32'(bus.pc), 32'h1C);
      chk("stall_val", 32'(bus.instr_valid), 32'h1);

      step(0, 0, 1, 9'h1FC, 0, '0);
      run(1);
      chk("wrap_0", 32'(bus.pc), 32'h0);

      step(0, 0, 1, 9'h040, 0, '0);
      step(0, 0, 1, 9'h080, 0, '0);
      chk("halt_pc", 32'(bus.pc), 32'h40);
      chk("halt_h", 32'(bus.halted), 32'h1);
      run(2);
      step(1, 0, 0, '0, 0, '0);
      chk("halt_rst", 32'(bus.halted), 32'h0);

      run(1);
      step(0, 0, 1, 9'h022, 0, '0);
      chk("mis_flag", 32'(bus.misaligned), 32'h1);
      chk("mis_pc", 32'(bus.pc), 32'h0);
      run(2);
      chk("mis_val", 32'(bus.instr_valid), 32'h0);
      step(1, 1, 1, 9'h044, 0, '0);
      chk("mis_rst", 32'(bus.misaligned), 32'h0);

      run(1);
      step(0, 0, 0, '0, 1, 9'h066);
      chk("jalr_mis", 32'(bus.misaligned), 32'h1);
      step(1, 0, 0, '0, 0, '0);

      for (int i = 0; i < 400; i++) begin
         bt = 9'($urandom);
         jt = 9'($urandom);
         if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) jt[1] = 1'b0;
         step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, bt,
              $urandom_range(0, 3) == 0, jt);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
